// File: rtl/bullet_pool_pkg.sv
// Shared types and constants for the bullet sprite pool.
package bullet_pool_pkg;

  localparam int COORD_W = 8;
  localparam int SIZE_W  = 8;
  localparam int COLOR_W = 3;

  localparam logic [COLOR_W-1:0] COL_WHITE = 3'd0;
  localparam logic [COLOR_W-1:0] COL_GREEN = 3'd1;
  localparam logic [COLOR_W-1:0] COL_BLUE  = 3'd2;

  // Default pool geometry and motion
  localparam int DEF_N_BULLETS = 8;
  localparam int DEF_W         = 16;
  localparam int DEF_H         = 16;
  localparam int DEF_SPEED     = 5;
  localparam int DEF_Y_LIMIT   = 200;
  localparam int DEF_Y_RESTART = 1;
  localparam bit DEF_WRAP      = 1'b1;

  typedef struct packed {
    logic               alive;
    logic [COLOR_W-1:0] color;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } bullet_t;

endpackage

// File: rtl/bullet_pool_if.sv
// Spawn channel plus the renderer and collision read ports of the bullet pool.
interface bullet_pool_if #(parameter int IDX_W = 3);
  import bullet_pool_pkg::*;

  logic               spawn_valid;
  logic               spawn_ready;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic [SIZE_W-1:0]  spawn_w;
  logic [SIZE_W-1:0]  spawn_h;
  logic [COLOR_W-1:0] spawn_color;

  logic [IDX_W-1:0]   vga_idx;
  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;
  logic [SIZE_W-1:0]  vga_w;
  logic [SIZE_W-1:0]  vga_h;
  logic [COLOR_W-1:0] vga_color;
  logic               vga_alive;

  logic [IDX_W-1:0]   hit_idx;
  logic               hit_clear;
  logic [COORD_W-1:0] hit_x;
  logic [COORD_W-1:0] hit_y;
  logic [SIZE_W-1:0]  hit_w;
  logic [SIZE_W-1:0]  hit_h;
  logic [COLOR_W-1:0] hit_color;
  logic               hit_alive;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h, spawn_color,
    output vga_idx, hit_idx, hit_clear,
    input  spawn_ready,
    input  vga_x, vga_y, vga_w, vga_h, vga_color, vga_alive,
    input  hit_x, hit_y, hit_w, hit_h, hit_color, hit_alive
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_w, spawn_h, spawn_color,
    input  vga_idx, hit_idx, hit_clear,
    output spawn_ready,
    output vga_x, vga_y, vga_w, vga_h, vga_color, vga_alive,
    output hit_x, hit_y, hit_w, hit_h, hit_color, hit_alive
  );

endinterface

// File: rtl/bullet_pool_free_slot_enc.sv
// Lowest-index free slot finder over the registered alive mask.
module bullet_pool_free_slot_enc #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     alive,
  output logic [IDX_W-1:0] free_idx,
  output logic             any_free
);

  // Scan high to low so the lowest dead index wins
  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!alive[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_free = ~&alive;

endmodule

// File: rtl/bullet_pool.sv
// Pool of moving bullet sprites: spawn handshake, per-tick motion, hit/flush retire.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int N_BULLETS = DEF_N_BULLETS,
  parameter int IDX_W     = $clog2(N_BULLETS),
  parameter int SPEED     = DEF_SPEED,
  parameter int Y_LIMIT   = DEF_Y_LIMIT,
  parameter int Y_RESTART = DEF_Y_RESTART,
  parameter bit WRAP      = DEF_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             tick,
  input  logic             flush,
  bullet_pool_if.slave     bus,
  output logic [IDX_W:0]   alive_count
);

  // One extra bit on the motion adder so an overflow counts as an edge hit
  localparam logic [COORD_W:0]   SPEED_W     = (COORD_W + 1)'(SPEED);
  localparam logic [COORD_W:0]   Y_LIMIT_W   = (COORD_W + 1)'(Y_LIMIT);
  localparam logic [COORD_W-1:0] Y_RESTART_W = COORD_W'(Y_RESTART);

  bullet_t [N_BULLETS-1:0] ent_q, ent_d;
  logic [IDX_W:0]          alive_count_q, alive_count_d;
  logic [N_BULLETS-1:0]    alive_vec;
  logic [IDX_W-1:0]        free_idx;
  logic                    any_free;
  logic                    spawn_fire;
  logic [COORD_W:0]        y_sum;

  // Gather the registered alive bits for the free finder and the popcount
  always_comb begin
    for (int i = 0; i < N_BULLETS; i++) alive_vec[i] = ent_q[i].alive;
  end

  bullet_pool_free_slot_enc #(.N(N_BULLETS), .IDX_W(IDX_W)) u_free (
    .alive    (alive_vec),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign bus.spawn_ready = any_free;
  assign spawn_fire      = bus.spawn_valid & any_free & ~flush;

  // Per-slot next state: flush, then hit clear, then spawn write, then motion
  always_comb begin
    ent_d = ent_q;
    y_sum = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (flush) begin
        ent_d[i].alive = 1'b0;
      end else if (bus.hit_clear && bus.hit_idx == IDX_W'(i) && ent_q[i].alive) begin
        ent_d[i].alive = 1'b0;
      end else if (spawn_fire && free_idx == IDX_W'(i)) begin
        ent_d[i].alive = 1'b1;
        ent_d[i].color = bus.spawn_color;
        ent_d[i].w     = bus.spawn_w;
        ent_d[i].h     = bus.spawn_h;
        ent_d[i].x     = bus.spawn_x;
        ent_d[i].y     = bus.spawn_y;
      end else if (run && tick && ent_q[i].alive) begin
        y_sum = {1'b0, ent_q[i].y} + SPEED_W;
        if (({1'b0, ent_q[i].y} >= Y_LIMIT_W) || y_sum[COORD_W]) begin
          if (WRAP) ent_d[i].y = Y_RESTART_W;
          else      ent_d[i].alive = 1'b0;
        end else begin
          ent_d[i].y = y_sum[COORD_W-1:0];
        end
      end
    end
  end

  // Live count of the current entries, seen one cycle after the alive change
  always_comb begin
    alive_count_d = '0;
    for (int i = 0; i < N_BULLETS; i++) alive_count_d = alive_count_d + (IDX_W + 1)'(alive_vec[i]);
  end

  // Entry array and live count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q         <= '0;
      alive_count_q <= '0;
    end else begin
      ent_q         <= ent_d;
      alive_count_q <= alive_count_d;
    end
  end

  assign alive_count = alive_count_q;

  assign bus.vga_x     = ent_q[bus.vga_idx].x;
  assign bus.vga_y     = ent_q[bus.vga_idx].y;
  assign bus.vga_w     = ent_q[bus.vga_idx].w;
  assign bus.vga_h     = ent_q[bus.vga_idx].h;
  assign bus.vga_color = ent_q[bus.vga_idx].color;
  assign bus.vga_alive = ent_q[bus.vga_idx].alive;

  assign bus.hit_x     = ent_q[bus.hit_idx].x;
  assign bus.hit_y     = ent_q[bus.hit_idx].y;
  assign bus.hit_w     = ent_q[bus.hit_idx].w;
  assign bus.hit_h     = ent_q[bus.hit_idx].h;
  assign bus.hit_color = ent_q[bus.hit_idx].color;
  assign bus.hit_alive = ent_q[bus.hit_idx].alive;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: wrap-mode DUT checked against a slot-array model every cycle,
// plus a retire-mode DUT checked against the same model until its behaviour legitimately diverges.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  localparam int NB = 8;
  localparam int SPD = 5;
  localparam int YLIM = 200;
  localparam int YRST = 1;

  logic clk, rst_n, run, tick, flush;
  logic [3:0] cnt_w, cnt_r;

  bullet_pool_if #(.IDX_W(3)) bus ();
  bullet_pool_if #(.IDX_W(3)) bus_r ();

  bullet_pool dut (
    .clk(clk), .rst_n(rst_n), .run(run), .tick(tick), .flush(flush),
    .bus(bus.slave), .alive_count(cnt_w)
  );

  bullet_pool #(.WRAP(1'b0)) dut_r (
    .clk(clk), .rst_n(rst_n), .run(run), .tick(tick), .flush(flush),
    .bus(bus_r.slave), .alive_count(cnt_r)
  );

  assign bus_r.spawn_valid = bus.spawn_valid;
  assign bus_r.spawn_x     = bus.spawn_x;
  assign bus_r.spawn_y     = bus.spawn_y;
  assign bus_r.spawn_w     = bus.spawn_w;
  assign bus_r.spawn_h     = bus.spawn_h;
  assign bus_r.spawn_color = bus.spawn_color;
  assign bus_r.vga_idx     = bus.vga_idx;
  assign bus_r.hit_idx     = bus.hit_idx;
  assign bus_r.hit_clear   = bus.hit_clear;

  int checks = 0;
  int errors = 0;
  bit same_en = 1'b1;

  int m_alive[NB], m_x[NB], m_y[NB], m_w[NB], m_h[NB], m_col[NB];
  int n_alive[NB], n_y[NB];
  int m_count = 0;
  int mf, mc;
  bit fire;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0d required=%0d at t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  function automatic int any_dead();
    for (int i = 0; i < NB; i++) if (m_alive[i] == 0) return 1;
    return 0;
  endfunction

  // Reference model: slot table updated by the pool rules on each clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        m_alive[i] = 0; m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0; m_col[i] = 0;
      end
      m_count = 0;
    end else begin
      mc = 0;
      mf = -1;
      for (int i = 0; i < NB; i++) begin
        mc += m_alive[i];
        if (m_alive[i] == 0 && mf < 0) mf = i;
      end
      fire = bus.spawn_valid && (mf >= 0) && !flush;
      for (int i = 0; i < NB; i++) begin
        n_alive[i] = m_alive[i];
        n_y[i] = m_y[i];
        if (flush) n_alive[i] = 0;
        else if (bus.hit_clear && int'(bus.hit_idx) == i) n_alive[i] = 0;
        else if (fire && i == mf) begin
          n_alive[i] = 1;
          n_y[i] = int'(bus.spawn_y);
          m_x[i] = int'(bus.spawn_x);
          m_w[i] = int'(bus.spawn_w);
          m_h[i] = int'(bus.spawn_h);
          m_col[i] = int'(bus.spawn_color);
        end else if (run && tick && m_alive[i] == 1) begin
          if (m_y[i] >= YLIM || m_y[i] + SPD > 255) n_y[i] = YRST;
          else n_y[i] = m_y[i] + SPD;
        end
      end
      for (int i = 0; i < NB; i++) begin
        m_alive[i] = n_alive[i];
        m_y[i] = n_y[i];
      end
      m_count = mc;
    end
  end

  // Every cycle: status, collision port, and a sweep of the render port over all slots
  initial begin
    int hi;
    bus.vga_idx = '0;
    @(negedge clk);
    forever begin
      #1;
      chk("spawn_ready", -1, int'(bus.spawn_ready), any_dead());
      chk("alive_count", -1, int'(cnt_w), m_count);
      hi = int'(bus.hit_idx);
      chk("hit_alive", hi, int'(bus.hit_alive), m_alive[hi]);
      chk("hit_x", hi, int'(bus.hit_x), m_x[hi]);
      chk("hit_y", hi, int'(bus.hit_y), m_y[hi]);
      chk("hit_w", hi, int'(bus.hit_w), m_w[hi]);
      chk("hit_h", hi, int'(bus.hit_h), m_h[hi]);
      chk("hit_color", hi, int'(bus.hit_color), m_col[hi]);
      if (same_en) begin
        chk("r_spawn_ready", -1, int'(bus_r.spawn_ready), any_dead());
        chk("r_alive_count", -1, int'(cnt_r), m_count);
      end
      for (int i = 0; i < NB; i++) begin
        bus.vga_idx = 3'(i);
        #1;
        chk("vga_alive", i, int'(bus.vga_alive), m_alive[i]);
        chk("vga_x", i, int'(bus.vga_x), m_x[i]);
        chk("vga_y", i, int'(bus.vga_y), m_y[i]);
        chk("vga_w", i, int'(bus.vga_w), m_w[i]);
        chk("vga_h", i, int'(bus.vga_h), m_h[i]);
        chk("vga_color", i, int'(bus.vga_color), m_col[i]);
        if (same_en) begin
          chk("r_vga_alive", i, int'(bus_r.vga_alive), m_alive[i]);
          chk("r_vga_y", i, int'(bus_r.vga_y), m_y[i]);
          chk("r_vga_x", i, int'(bus_r.vga_x), m_x[i]);
        end
      end
      @(negedge clk);
    end
  end

  task automatic set_spawn(input int x, input int y, input int w, input int h, input int c);
    bus.spawn_x = 8'(x); bus.spawn_y = 8'(y);
    bus.spawn_w = 8'(w); bus.spawn_h = 8'(h);
    bus.spawn_color = 3'(c);
  endtask

  task automatic peek(input int idx);
    #2;
    bus.hit_idx = 3'(idx);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations
  initial begin
    rst_n = 1'b1; run = 1'b0; tick = 1'b0; flush = 1'b0;
    bus.spawn_valid = 1'b0; bus.hit_idx = '0; bus.hit_clear = 1'b0;
    set_spawn(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    peek(0);
    chk("lit_reset_ready", -1, int'(bus.spawn_ready), 1);
    chk("lit_reset_count", -1, int'(cnt_w), 0);
    chk("lit_reset_alive", 0, int'(bus.hit_alive), 0);

    // single spawn into slot 0
    @(negedge clk);
    set_spawn(16, 19, DEF_W, DEF_H, int'(COL_BLUE));
    bus.spawn_valid = 1'b1;
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    peek(0);
    chk("lit_t1_alive", 0, int'(bus.hit_alive), 1);
    chk("lit_t1_x", 0, int'(bus.hit_x), 16);
    chk("lit_t1_y", 0, int'(bus.hit_y), 19);
    chk("lit_t1_w", 0, int'(bus.hit_w), 16);
    chk("lit_t1_color", 0, int'(bus.hit_color), 2);
    chk("lit_t1_count_lag", -1, int'(cnt_w), 0);
    @(negedge clk);
    #2 chk("lit_t1_count", -1, int'(cnt_w), 1);

    // fill the pool back-to-back, then a 9th request must be ignored
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < NB; i++) begin
      set_spawn(8 * i + 1, 10 + i, 4, 6, i % 3);
      bus.spawn_valid = 1'b1;
      @(negedge clk);
    end
    set_spawn(200, 99, 9, 9, 1);
    #2 chk("lit_t2_full_ready", -1, int'(bus.spawn_ready), 0);
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    peek(7);
    chk("lit_t2_s7_x", 7, int'(bus.hit_x), 57);
    chk("lit_t2_s7_y", 7, int'(bus.hit_y), 17);
    chk("lit_t2_count", -1, int'(cnt_w), 8);

    // hit clear on slot 3 while moving, with a spawn request pending
    @(negedge clk);
    bus.hit_idx = 3'd3; bus.hit_clear = 1'b1; run = 1'b1; tick = 1'b1;
    set_spawn(99, 50, 2, 2, int'(COL_GREEN));
    bus.spawn_valid = 1'b1;
    @(negedge clk);
    bus.hit_clear = 1'b0; tick = 1'b0;
    peek(3);
    chk("lit_t4_s3_alive", 3, int'(bus.hit_alive), 0);
    chk("lit_t4_s3_y", 3, int'(bus.hit_y), 13);
    bus.hit_idx = 3'd0;
    #1 chk("lit_t4_s0_y", 0, int'(bus.hit_y), 15);
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    peek(3);
    chk("lit_t4_s3_respawn", 3, int'(bus.hit_alive), 1);
    chk("lit_t4_s3_newy", 3, int'(bus.hit_y), 50);

    // frozen motion: ticks with run=0, spawn into a freshly cleared slot still works
    @(negedge clk);
    run = 1'b0;
    bus.hit_idx = 3'd5; bus.hit_clear = 1'b1;
    @(negedge clk);
    bus.hit_clear = 1'b0;
    tick = 1'b1;
    set_spawn(7, 77, 1, 1, int'(COL_WHITE));
    bus.spawn_valid = 1'b1;
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    repeat (9) @(negedge clk);
    tick = 1'b0;
    peek(0);
    chk("lit_t5_s0_y", 0, int'(bus.hit_y), 15);
    bus.hit_idx = 3'd5;
    #1 chk("lit_t5_s5_y", 5, int'(bus.hit_y), 77);
    chk("lit_t5_s5_alive", 5, int'(bus.hit_alive), 1);

    // edge behaviour: wrap vs retire from y=195
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_spawn(5, 195, 3, 3, 1);
    bus.spawn_valid = 1'b1;
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    run = 1'b1; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    peek(0);
    chk("lit_t3_wrap_y1", 0, int'(bus.hit_y), 200);
    chk("lit_t3_retire_y1", 0, int'(bus_r.hit_y), 200);
    @(negedge clk);
    same_en = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    peek(0);
    chk("lit_t3_wrap_y2", 0, int'(bus.hit_y), 1);
    chk("lit_t3_wrap_alive", 0, int'(bus.hit_alive), 1);
    chk("lit_t3_retire_y2", 0, int'(bus_r.hit_y), 200);
    chk("lit_t3_retire_alive", 0, int'(bus_r.hit_alive), 0);

    // flush with a simultaneous spawn request
    @(negedge clk);
    run = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_spawn(30, 40, 5, 5, 2);
    bus.spawn_valid = 1'b1;
    @(negedge clk);
    set_spawn(31, 41, 5, 5, 1);
    @(negedge clk);
    flush = 1'b1;
    set_spawn(32, 42, 5, 5, 0);
    @(negedge clk);
    flush = 1'b0;
    bus.spawn_valid = 1'b0;
    peek(0);
    chk("lit_t6_flush_alive", 0, int'(bus.hit_alive), 0);
    chk("lit_t6_flush_ready", -1, int'(bus.spawn_ready), 1);
    chk("lit_t6_count_lag", -1, int'(cnt_w), 2);
    @(negedge clk);
    #2 chk("lit_t6_count", -1, int'(cnt_w), 0);

    // asynchronous reset in the middle of motion with a spawn pending
    @(negedge clk);
    set_spawn(60, 70, 8, 8, 2);
    bus.spawn_valid = 1'b1;
    run = 1'b1; tick = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    peek(0);
    chk("lit_rst_alive", 0, int'(bus.hit_alive), 0);
    chk("lit_rst_x", 0, int'(bus.hit_x), 0);
    chk("lit_rst_y", 0, int'(bus.hit_y), 0);
    chk("lit_rst_count", -1, int'(cnt_w), 0);
    chk("lit_rst_ready", -1, int'(bus.spawn_ready), 1);
    chk("lit_rst_r_alive", 0, int'(bus_r.hit_alive), 0);
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    rst_n = 1'b1;
    same_en = 1'b1;
    @(negedge clk);
    set_spawn(11, 22, 3, 4, 1);
    bus.spawn_valid = 1'b1;
    @(negedge clk);
    bus.spawn_valid = 1'b0;
    repeat (4) @(negedge clk);
    tick = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
